// File: rtl/sig_pkg.sv
// -----------------------------------------------------------------------------
// sig_pkg
// Shared types and helpers for the sig_echo delay/echo block.
//   - mode_t     : processing mode encoding (bypass, delay, mix, echo)
//   - sat_signed : clamp a signed value to the range of a narrower signed width
//   - DEF_*      : default parameter widths
// -----------------------------------------------------------------------------
package sig_pkg;

    localparam int DEF_ADDRESS_WIDTH = 9;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_GAIN_WIDTH    = 4;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DELAY  = 2'b01,
        MODE_MIX    = 2'b10,
        MODE_ECHO   = 2'b11
    } mode_t;

    // Clamp a 32-bit signed value to [-2^(width-1), 2^(width-1)-1].
    // The caller keeps the low 'width' bits of the result.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (width - 1));
        if (value > max_v) begin
            sat_signed = max_v;
        end else if (value < min_v) begin
            sat_signed = min_v;
        end else begin
            sat_signed = value;
        end
    endfunction

endpackage

// File: rtl/sig_echo_ram2ports.sv
// -----------------------------------------------------------------------------
// ram2ports
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// with a registered output. Contents are not reset. A read and a write to the
// same address in the same cycle returns the old contents; callers that need
// the new value must forward it themselves.
// Ports:
//   clk        : clock, rising edge
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read enable (output register updates only when set)
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, valid the cycle after i_rd_en
// -----------------------------------------------------------------------------
module ram2ports #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_rd_en,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sig_echo.sv
// -----------------------------------------------------------------------------
// sig_echo
// Sample-strobed delay line with bypass, delay, dry/wet mix and feedback echo.
// Two-stage pipeline: S0 accepts a sample and issues the delayed read, S1
// computes the result and writes the delay line; the output is registered, so
// each accepted sample produces a one-cycle out_valid pulse two cycles later.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   sample_valid : sample_in is accepted this cycle
//   sample_in    : signed input sample
//   delay        : delay in samples (0 behaves as 1)
//   mode         : 00 bypass, 01 delay, 10 mix, 11 echo
//   fb_gain      : unsigned echo gain, value g means g/2^GAIN_WIDTH
//   sample_out   : signed processed sample
//   out_valid    : sample_out valid this cycle
//   primed       : enough samples written since reset/delay change
// -----------------------------------------------------------------------------
module sig_echo
    import sig_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH    = DEF_GAIN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic [ADDRESS_WIDTH-1:0]     delay,
    input  logic [1:0]                   mode,
    input  logic [GAIN_WIDTH-1:0]        fb_gain,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         out_valid,
    output logic                         primed
);

    localparam int MW = DATA_WIDTH + 1;               // mix sum width
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;  // echo product width
    localparam int EW = PW + 1;                       // echo sum width

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = {ADDRESS_WIDTH{1'b1}};

    // ---------------- state ----------------
    logic [ADDRESS_WIDTH-1:0]     r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0]     r_fill;
    logic [ADDRESS_WIDTH-1:0]     r_delay;
    logic                         r_primed;

    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_in;
    logic [ADDRESS_WIDTH-1:0]     r_s1_addr;
    logic                         r_s1_primed;
    mode_t                        r_s1_mode;
    logic [GAIN_WIDTH-1:0]        r_s1_gain;
    logic                         r_fwd_hit;
    logic signed [DATA_WIDTH-1:0] r_fwd_data;

    logic signed [DATA_WIDTH-1:0] r_out;
    logic                         r_out_valid;

    // ---------------- combinational ----------------
    logic [ADDRESS_WIDTH-1:0]     w_eff_delay;
    logic [ADDRESS_WIDTH-1:0]     w_rd_addr;
    logic                         w_delay_chg;
    logic                         w_primed_now;
    logic                         w_fwd_hit;
    logic [ADDRESS_WIDTH-1:0]     w_fill_base;
    logic [ADDRESS_WIDTH-1:0]     w_fill_next;

    logic [DATA_WIDTH-1:0]        w_ram_dout;
    logic signed [DATA_WIDTH-1:0] w_d;
    logic signed [MW-1:0]         w_mix_sum;
    logic signed [DATA_WIDTH-1:0] w_mix;
    logic signed [PW-1:0]         w_d_ext;
    logic signed [PW-1:0]         w_gain_ext;
    logic signed [PW-1:0]         w_prod;
    logic signed [PW-1:0]         w_prod_sh;
    logic signed [EW-1:0]         w_echo_sum;
    logic signed [31:0]           w_echo_sat_full;
    logic signed [DATA_WIDTH-1:0] w_echo_sat;
    logic signed [DATA_WIDTH-1:0] w_s1_result;
    logic signed [DATA_WIDTH-1:0] w_s1_wdata;

    logic                         w_ram_wr_en;
    logic                         w_ram_rd_en;

    // S0 address generation, delay-change detection and forwarding compare.
    always_comb begin
        w_eff_delay = (delay == '0) ? ADDR_ONE : delay;
        w_rd_addr   = r_wr_ptr - w_eff_delay;
        w_delay_chg = (delay != r_delay);
        // A changed delay invalidates the fill count right away, so a sample
        // arriving in the same cycle must not trust the old count.
        w_primed_now = (!w_delay_chg) && (r_fill >= w_eff_delay);
        // The sample in S1 writes its slot this cycle; a read of that same
        // slot would see stale RAM contents.
        w_fwd_hit = r_s1_valid && (w_rd_addr == r_s1_addr);
    end

    // Next fill count: cleared by a delay change, saturating at FILL_MAX.
    always_comb begin
        w_fill_base = w_delay_chg ? '0 : r_fill;
        if (sample_valid && (w_fill_base != FILL_MAX)) begin
            w_fill_next = w_fill_base + ADDR_ONE;
        end else begin
            w_fill_next = w_fill_base;
        end
    end

    // S1 datapath: delayed sample selection and per-mode arithmetic.
    always_comb begin
        w_d = '0;
        if (r_s1_primed) begin
            if (r_fwd_hit) begin
                w_d = r_fwd_data;
            end else begin
                w_d = w_ram_dout;
            end
        end else begin
            w_d = '0;
        end

        // Average of dry and delayed: one extra bit so the sum cannot wrap.
        w_mix_sum = MW'(r_s1_in) + MW'(w_d);
        w_mix     = w_mix_sum[MW-1:1];

        // Echo: in + d*g/2^GAIN_WIDTH, then clamp.
        w_d_ext         = PW'(w_d);
        w_gain_ext      = PW'(r_s1_gain);
        w_prod          = w_d_ext * w_gain_ext;
        w_prod_sh       = w_prod >>> GAIN_WIDTH;
        w_echo_sum      = EW'(w_prod_sh) + EW'(r_s1_in);
        w_echo_sat_full = sat_signed(32'(w_echo_sum), DATA_WIDTH);
        w_echo_sat      = w_echo_sat_full[DATA_WIDTH-1:0];

        w_s1_result = r_s1_in;
        w_s1_wdata  = r_s1_in;
        case (r_s1_mode)
            MODE_BYPASS: begin
                w_s1_result = r_s1_in;
                w_s1_wdata  = r_s1_in;
            end
            MODE_DELAY: begin
                w_s1_result = w_d;
                w_s1_wdata  = r_s1_in;
            end
            MODE_MIX: begin
                w_s1_result = w_mix;
                w_s1_wdata  = r_s1_in;
            end
            MODE_ECHO: begin
                w_s1_result = w_echo_sat;
                w_s1_wdata  = w_echo_sat;
            end
            default: begin
                w_s1_result = r_s1_in;
                w_s1_wdata  = r_s1_in;
            end
        endcase
    end

    // RAM strobes; reset suppresses both, including the in-flight S1 write.
    always_comb begin
        w_ram_wr_en = r_s1_valid && !rst;
        w_ram_rd_en = sample_valid && !rst;
    end

    ram2ports #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_wr_en),
        .i_wr_addr (r_s1_addr),
        .i_wr_data (w_s1_wdata),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_dout)
    );

    // Write pointer, fill tracking and registered primed flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_primed <= 1'b0;
            // Track the live delay so leaving reset is not seen as a change.
            r_delay  <= delay;
        end else begin
            r_delay  <= delay;
            r_fill   <= w_fill_next;
            r_primed <= (w_fill_next >= w_eff_delay);
            if (sample_valid) begin
                r_wr_ptr <= r_wr_ptr + ADDR_ONE;
            end
        end
    end

    // S0 -> S1 pipeline registers, including the forwarded write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_in     <= '0;
            r_s1_addr   <= '0;
            r_s1_primed <= 1'b0;
            r_s1_mode   <= MODE_BYPASS;
            r_s1_gain   <= '0;
            r_fwd_hit   <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_s1_valid <= sample_valid;
            if (sample_valid) begin
                r_s1_in     <= sample_in;
                r_s1_addr   <= r_wr_ptr;
                r_s1_primed <= w_primed_now;
                r_s1_mode   <= mode_t'(mode);
                r_s1_gain   <= fb_gain;
                r_fwd_hit   <= w_fwd_hit;
                r_fwd_data  <= w_s1_wdata;
            end
        end
    end

    // Output register: one pulse per sample leaving S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_s1_result;
            end
        end
    end

    assign sample_out = r_out;
    assign out_valid  = r_out_valid;
    assign primed     = r_primed;

endmodule

// File: tb/tb_sig_echo.sv
// -----------------------------------------------------------------------------
// tb_sig_echo
// Directed-vector bench for sig_echo. Instance u_dut_a uses default widths;
// u_dut_b uses ADDRESS_WIDTH=4 for the pointer-wrap case. Both share the
// stimulus except for their delay inputs. Outputs are collected at the
// falling edge whenever out_valid is high and compared with hand-computed lists.
// -----------------------------------------------------------------------------
module tb_sig_echo;

    logic              clk;
    logic              rst;
    logic              sample_valid;
    logic signed [7:0] sample_in;
    logic [8:0]        delay_a;
    logic [3:0]        delay_b;
    logic [1:0]        mode;
    logic [3:0]        fb_gain;

    logic signed [7:0] sample_out_a;
    logic              out_valid_a;
    logic              primed_a;
    logic signed [7:0] sample_out_b;
    logic              out_valid_b;
    logic              primed_b;

    int n_tests;
    int n_fail;
    int q_a[$];
    int q_b[$];
    int exp_q[$];

    sig_echo u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delay        (delay_a),
        .mode         (mode),
        .fb_gain      (fb_gain),
        .sample_out   (sample_out_a),
        .out_valid    (out_valid_a),
        .primed       (primed_a)
    );

    sig_echo #(
        .ADDRESS_WIDTH (4)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delay        (delay_b),
        .mode         (mode),
        .fb_gain      (fb_gain),
        .sample_out   (sample_out_b),
        .out_valid    (out_valid_b),
        .primed       (primed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output collectors.
    always @(negedge clk) begin
        if (out_valid_a) q_a.push_back(int'(sample_out_a));
        if (out_valid_b) q_b.push_back(int'(sample_out_b));
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int v);
        sample_valid = 1'b1;
        sample_in    = v[7:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        sample_in    = 8'sd0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_q();
        q_a.delete();
        q_b.delete();
        exp_q.delete();
    endtask

    // Compare a collected output list against exp_q, element by element.
    task automatic compare_list(input string tag, input int got[$]);
        int n;
        check_val({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'sd0;
        delay_a      = 9'd3;
        delay_b      = 4'd15;
        mode         = 2'b01;
        fb_gain      = 4'd0;
        repeat (2) @(negedge clk);
        check_val("rst_out",    int'(sample_out_a), 0);
        check_val("rst_valid",  int'(out_valid_a),  0);
        check_val("rst_primed", int'(primed_a),     0);
        rst = 1'b0;
        idle(1);
        clear_q();

        // ---- delay=3, stream 10..50 ----
        send(10);
        check_val("lat_t1_valid", int'(out_valid_a), 0);
        send(20);
        check_val("lat_t2_valid", int'(out_valid_a), 1);
        check_val("primed_after2", int'(primed_a), 0);
        send(30);
        check_val("primed_after3", int'(primed_a), 1);
        send(40);
        send(50);
        idle(4);
        check_val("pulse_low", int'(out_valid_a), 0);
        exp_q = '{0, 0, 0, 10, 20};
        compare_list("delay3", q_a);
        clear_q();

        // ---- echo, delay=1, gain=8, impulse (forwarding path) ----
        mode    = 2'b11;
        delay_a = 9'd1;
        fb_gain = 4'd8;
        do_reset();
        send(64);
        for (int i = 0; i < 7; i++) send(0);
        idle(4);
        exp_q = '{64, 32, 16, 8, 4, 2, 1, 0};
        compare_list("echo_imp", q_a);
        clear_q();

        // ---- echo saturation, gain=15 ----
        fb_gain = 4'd15;
        do_reset();
        for (int i = 0; i < 6; i++) send(127);
        idle(4);
        exp_q = '{127, 127, 127, 127, 127, 127};
        compare_list("sat_pos", q_a);
        clear_q();
        do_reset();
        for (int i = 0; i < 6; i++) send(-128);
        idle(4);
        exp_q = '{-128, -128, -128, -128, -128, -128};
        compare_list("sat_neg", q_a);
        clear_q();

        // ---- ADDRESS_WIDTH=4, delay=15, ramp across pointer wrap ----
        mode    = 2'b01;
        delay_b = 4'd15;
        do_reset();
        for (int n = 0; n < 40; n++) send(n);
        idle(4);
        check_val("wrap_primed", int'(primed_b), 1);
        for (int n = 0; n < 40; n++) exp_q.push_back((n < 15) ? 0 : n - 15);
        compare_list("wrap", q_b);
        clear_q();

        // ---- delay change 3 -> 5 mid-stream ----
        mode    = 2'b01;
        delay_a = 9'd3;
        do_reset();
        for (int n = 1; n <= 6; n++) send(n);
        idle(3);
        check_val("dchg_primed_before", int'(primed_a), 1);
        clear_q();
        delay_a = 9'd5;
        idle(1);
        check_val("dchg_primed_after", int'(primed_a), 0);
        for (int n = 7; n <= 16; n++) send(n);
        idle(4);
        exp_q = '{0, 0, 0, 0, 0, 7, 8, 9, 10, 11};
        compare_list("dchg", q_a);
        clear_q();

        // ---- mix ----
        mode    = 2'b10;
        delay_a = 9'd1;
        do_reset();
        send(50);
        send(100);
        idle(4);
        exp_q = '{25, 75};
        compare_list("mix_pos", q_a);
        clear_q();
        do_reset();
        send(-100);
        send(-50);
        idle(4);
        exp_q = '{-50, -75};
        compare_list("mix_neg", q_a);
        clear_q();

        // ---- reset mid-stream with sample_valid held high ----
        mode    = 2'b01;
        delay_a = 9'd2;
        do_reset();
        for (int n = 1; n <= 5; n++) send(n);
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 8'sd6;
        @(negedge clk);
        check_val("mrst_valid",  int'(out_valid_a),  0);
        check_val("mrst_out",    int'(sample_out_a), 0);
        check_val("mrst_primed", int'(primed_a),     0);
        rst = 1'b0;
        clear_q();
        send(21);
        send(22);
        send(23);
        send(24);
        idle(4);
        exp_q = '{0, 0, 21, 22};
        compare_list("mrst", q_a);
        clear_q();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
